// File: rtl/pano_button_debounce_if.sv
// Signal bundle between the front-panel button conditioner and its consumer.
// The slave side is the conditioner; the master side drives the pad and clear.
interface pano_button_debounce_if;
  logic       button_i;
  logic       clear_count_i;
  logic       button_o;
  logic       press_o;
  logic       release_o;
  logic       long_press_o;
  logic [7:0] click_count_o;

  modport slave (
    input  button_i, clear_count_i,
    output button_o, press_o, release_o, long_press_o, click_count_o
  );

  modport master (
    output button_i, clear_count_i,
    input  button_o, press_o, release_o, long_press_o, click_count_o
  );
endinterface

// File: rtl/pano_button_debounce.sv
// Pano front-panel button conditioner: synchroniser, debounce FSM, press/release
// pulses and a saturating click counter. Long-press timer gated by PANO_BUTTON_LONG_PRESS_EN.
module pano_button_debounce #(
  parameter int CLK_FREQ      = 60000000,
  parameter int DEBOUNCE_US   = 10000,
  parameter int LONG_PRESS_MS = 2000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  master_clk,
  input  logic                  rst,
  pano_button_debounce_if.slave bus
);

  localparam int DEB_CYCLES = (CLK_FREQ / 1000000) * DEBOUNCE_US;
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1);
  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             sync1_q, sync2_q;
  logic             pressed_s;
  logic             holding;
  logic [7:0]       click_cnt_q;

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= bus.button_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = sync2_q ^ IDLE_LEVEL;

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The transition fires on the edge where the count would reach DEB_CYCLES,
  // so the registered pulse and the new state appear together.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d   = PRESS_PEND;
          deb_cnt_d = CNT_ONE;
        end
      end
      PRESS_PEND: begin
        if (!pressed_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
          press_d   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_d   = RELEASE_PEND;
          deb_cnt_d = CNT_ONE;
        end
      end
      RELEASE_PEND: begin
        if (pressed_s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  assign holding       = (state_q == PRESSED) || (state_q == RELEASE_PEND);
  assign bus.button_o  = holding;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;

  // A clear coinciding with a press yields 1 so that press is not lost.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      click_cnt_q <= 8'd0;
    end else if (press_q) begin
      if (bus.clear_count_i)
        click_cnt_q <= 8'd1;
      else if (click_cnt_q != 8'hFF)
        click_cnt_q <= click_cnt_q + 8'd1;
    end else if (bus.clear_count_i) begin
      click_cnt_q <= 8'd0;
    end
  end

  assign bus.click_count_o = click_cnt_q;

`ifdef PANO_BUTTON_LONG_PRESS_EN
  localparam int MS_DIV = CLK_FREQ / 1000;
  localparam int PRE_W  = $clog2(MS_DIV + 1);
  localparam int MS_W   = $clog2(LONG_PRESS_MS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(MS_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [MS_W-1:0]  MS_LIMIT  = MS_W'(LONG_PRESS_MS);
  localparam logic [MS_W-1:0]  MS_BEFORE = MS_W'(LONG_PRESS_MS - 1);
  localparam logic [MS_W-1:0]  MS_ONE    = MS_W'(1);

  logic [PRE_W-1:0] prescale_q;
  logic [MS_W-1:0]  ms_q;
  logic             long_q;

  // Saturating at the limit keeps the pulse one-shot for an arbitrarily long hold.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      ms_q       <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_q || !holding) begin
        prescale_q <= '0;
        ms_q       <= '0;
      end else if (ms_q != MS_LIMIT) begin
        if (prescale_q == PRE_LAST) begin
          prescale_q <= '0;
          ms_q       <= ms_q + MS_ONE;
          if (ms_q == MS_BEFORE)
            long_q <= 1'b1;
        end else begin
          prescale_q <= prescale_q + PRE_ONE;
        end
      end
    end
  end

  assign bus.long_press_o = long_q;
`else
  assign bus.long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_pano_button_debounce.sv
// Scoreboard bench for pano_button_debounce: expected events are queued when the
// pad is driven and matched by cycle when the DUT pulses them.
module tb_pano_button_debounce;
  localparam int CLK_FREQ      = 1000000;
  localparam int DEBOUNCE_US   = 100;
  localparam int LONG_PRESS_MS = 5;
  localparam int ACTIVE_LOW    = 1;
  localparam int DEB_CYCLES    = 100;
  localparam int LATENCY       = DEB_CYCLES + 2;
  localparam int LONG_DELAY    = LONG_PRESS_MS * 1000;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;
  localparam int EV_NONE    = 9;

  typedef struct {
    int kind;
    int cycle;
    int tol;
  } exp_ev_t;

  logic    master_clk = 1'b0;
  logic    rst = 1'b1;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      exp_count = 0;
  exp_ev_t exp_q[$];

  pano_button_debounce_if btn_if();

  pano_button_debounce #(
    .CLK_FREQ      (CLK_FREQ),
    .DEBOUNCE_US   (DEBOUNCE_US),
    .LONG_PRESS_MS (LONG_PRESS_MS),
    .ACTIVE_LOW    (ACTIVE_LOW)
  ) dut (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (btn_if.slave)
  );

  always #5 master_clk = ~master_clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic push_expect(input int kind, input int delay, input int tol);
    exp_ev_t e;
    e.kind  = kind;
    e.cycle = cyc + delay;
    e.tol   = tol;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic level, input int kind);
    btn_if.button_i = level;
    if (kind != EV_NONE)
      push_expect(kind, LATENCY, 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge master_clk);
  endtask

  task automatic handle_event(input int kind);
    exp_ev_t e;
    int diff;
    if (exp_q.size() == 0) begin
      check_output("unexpected_event", kind, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      check_output("event_kind", kind, e.kind);
      diff = cyc - e.cycle;
      if (diff < 0) diff = -diff;
      if (e.tol == 0)
        check_output("event_cycle", cyc, e.cycle);
      else
        check_output("event_window", 32'(diff <= e.tol), 1);
    end
  endtask

  // Monitor samples 1 time unit after each active edge.
  always @(posedge master_clk) begin
    cyc = cyc + 1;
    #1;
    if (btn_if.press_o === 1'b1)      handle_event(EV_PRESS);
    if (btn_if.release_o === 1'b1)    handle_event(EV_RELEASE);
    if (btn_if.long_press_o === 1'b1) handle_event(EV_LONG);
    if (btn_if.press_o === 1'b1 && btn_if.release_o === 1'b1)
      check_output("press_release_overlap", 1, 0);
  end

  task automatic click();
    apply_stimulus(1'b0, EV_PRESS);
    wait_cycles(105);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(105);
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    btn_if.button_i      = 1'b1;
    btn_if.clear_count_i = 1'b0;
    wait_cycles(5);
    check_output("rst_button_o", btn_if.button_o, 0);
    check_output("rst_press_o", btn_if.press_o, 0);
    check_output("rst_release_o", btn_if.release_o, 0);
    check_output("rst_long_press_o", btn_if.long_press_o, 0);
    check_output("rst_click_count", btn_if.click_count_o, 0);
    rst = 1'b0;
    wait_cycles(10);

    $display("[TB] clean press and release");
    apply_stimulus(1'b0, EV_PRESS);
    wait_cycles(LATENCY);
    check_output("t1_press_o", btn_if.press_o, 1);
    check_output("t1_button_o", btn_if.button_o, 1);
    check_output("t1_count_before", btn_if.click_count_o, 0);
    wait_cycles(1);
    exp_count = 1;
    check_output("t1_count_after", btn_if.click_count_o, exp_count);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(LATENCY - 1);
    check_output("t1_button_still_1", btn_if.button_o, 1);
    wait_cycles(1);
    check_output("t1_button_o_low", btn_if.button_o, 0);
    wait_cycles(20);

    $display("[TB] bouncing pad");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, EV_NONE);
      wait_cycles(50);
      apply_stimulus(1'b1, EV_NONE);
      wait_cycles(10);
    end
    check_output("t2_button_o", btn_if.button_o, 0);
    check_output("t2_count_held", btn_if.click_count_o, exp_count);
    apply_stimulus(1'b0, EV_PRESS);
    wait_cycles(200);
    exp_count++;
    check_output("t2_count", btn_if.click_count_o, exp_count);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(150);

    $display("[TB] long hold");
    apply_stimulus(1'b0, EV_PRESS);
`ifdef PANO_BUTTON_LONG_PRESS_EN
    push_expect(EV_LONG, LATENCY + LONG_DELAY, 10);
`endif
    wait_cycles(6000);
    check_output("t3_button_o", btn_if.button_o, 1);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(150);
    exp_count++;
    check_output("t3_count", btn_if.click_count_o, exp_count);

    $display("[TB] open bounce while pressed");
    apply_stimulus(1'b0, EV_PRESS);
`ifdef PANO_BUTTON_LONG_PRESS_EN
    push_expect(EV_LONG, LATENCY + LONG_DELAY, 10);
`endif
    wait_cycles(1000);
    apply_stimulus(1'b1, EV_NONE);
    wait_cycles(20);
    check_output("t6_button_mid_gap", btn_if.button_o, 1);
    wait_cycles(20);
    apply_stimulus(1'b0, EV_NONE);
    wait_cycles(100);
    check_output("t6_button_after_gap", btn_if.button_o, 1);
    wait_cycles(4880);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(150);
    exp_count++;
    check_output("t6_count", btn_if.click_count_o, exp_count);

    $display("[TB] click counter saturation");
    for (int i = 0; i < 300; i++) begin
      click();
      if (exp_count >= 254)
        check_output("t4_click_sat", btn_if.click_count_o, exp_count);
    end
    apply_stimulus(1'b0, EV_PRESS);
    wait_cycles(LATENCY);
    check_output("t4_press_at_clear", btn_if.press_o, 1);
    btn_if.clear_count_i = 1'b1;
    wait_cycles(1);
    btn_if.clear_count_i = 1'b0;
    check_output("t4_clear_with_press", btn_if.click_count_o, 1);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(150);
    btn_if.clear_count_i = 1'b1;
    wait_cycles(1);
    btn_if.clear_count_i = 1'b0;
    check_output("t4_clear_alone", btn_if.click_count_o, 0);
    wait_cycles(10);

    $display("[TB] reset during pending press");
    apply_stimulus(1'b0, EV_NONE);
    wait_cycles(50);
    rst = 1'b1;
    wait_cycles(5);
    check_output("t5_rst_button_o", btn_if.button_o, 0);
    check_output("t5_rst_press_o", btn_if.press_o, 0);
    check_output("t5_rst_release_o", btn_if.release_o, 0);
    check_output("t5_rst_count", btn_if.click_count_o, 0);
    rst = 1'b0;
    push_expect(EV_PRESS, LATENCY, 0);
    wait_cycles(LATENCY);
    check_output("t5_button_o", btn_if.button_o, 1);
    wait_cycles(1);
    check_output("t5_count", btn_if.click_count_o, 1);
    apply_stimulus(1'b1, EV_RELEASE);
    wait_cycles(200);

    check_output("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
